// File: rtl/id_ex_pkg.sv
// ID->EXE payload description: default widths, field offsets, payload width
// and the mask that selects the control bits cleared in a bubble.
// Layout, MSB first: WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, valRn,
// valRm, imm, shiftOperand[11:0], signedIMM[23:0], dest.
package id_ex_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CMD_W  = 4;
    localparam int DEF_DEST_W = 4;
    localparam int DEF_CNT_W  = 16;

    localparam int CTRL_W  = 5;
    localparam int SHIFT_W = 12;
    localparam int SIMM_W  = 24;

    // Bit positions inside the control field (field LSB = S).
    localparam int CTRL_S_BIT     = 0;
    localparam int CTRL_B_BIT     = 1;
    localparam int CTRL_MEM_W_BIT = 2;
    localparam int CTRL_MEM_R_BIT = 3;
    localparam int CTRL_WB_BIT    = 4;

    // Control bits that must read 0 while the stage holds no instruction.
    localparam logic [CTRL_W-1:0] CTRL_MASK = 5'b11111;

    function automatic int payload_w(input int data_w, input int cmd_w, input int dest_w);
        return CTRL_W + cmd_w + 3 * data_w + 1 + SHIFT_W + SIMM_W + dest_w;
    endfunction

    function automatic int off_dest();
        return 0;
    endfunction

    function automatic int off_simm(input int dest_w);
        return dest_w;
    endfunction

    function automatic int off_shift(input int dest_w);
        return dest_w + SIMM_W;
    endfunction

    function automatic int off_imm(input int dest_w);
        return dest_w + SIMM_W + SHIFT_W;
    endfunction

    function automatic int off_valrm(input int dest_w);
        return off_imm(dest_w) + 1;
    endfunction

    function automatic int off_valrn(input int data_w, input int dest_w);
        return off_valrm(dest_w) + data_w;
    endfunction

    function automatic int off_pc(input int data_w, input int dest_w);
        return off_valrn(data_w, dest_w) + data_w;
    endfunction

    function automatic int off_cmd(input int data_w, input int dest_w);
        return off_pc(data_w, dest_w) + data_w;
    endfunction

    function automatic int off_ctrl(input int data_w, input int cmd_w, input int dest_w);
        return off_cmd(data_w, dest_w) + cmd_w;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic one-deep pipeline register with valid/ready handshake and flush.
// Build option ID_EX_SKID_BUFFER_EN: adds a skid register so in_ready is a
// registered signal (no combinational path from out_ready to in_ready).
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic         in_xfer;
    logic         out_xfer;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_xfer  = main_valid_q && out_ready;

`ifdef ID_EX_SKID_BUFFER_EN
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign in_xfer  = in_valid && in_ready_q;

    // Next state: main drains/refills first (from skid, else from input);
    // an input arriving while main is stuck is parked in the skid register.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset empties both slots and opens the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

    // Next state: flush kills everything, otherwise load on input transfer
    // or go empty once the held entry has been taken.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
        end
    end

    // State register; reset empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
        end
    end
`endif

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID->EXE pipeline stage register: handshake storage via pipe_skid_buf,
// control-bit masking for bubbles, flush wiring and a saturating counter of
// back-pressured cycles. Build option ID_EX_SKID_BUFFER_EN selects the
// skid-buffered storage (see pipe_skid_buf).
module id_ex_stage_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CMD_W  = DEF_CMD_W,
    parameter int DEST_W = DEF_DEST_W,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int PAYLOAD_W = payload_w(DATA_W, CMD_W, DEST_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int CTRL_LO = off_ctrl(DATA_W, CMD_W, DEST_W);

    logic                 held_valid;
    logic [PAYLOAD_W-1:0] held_payload;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (held_valid),
        .out_ready (out_ready),
        .out_data  (held_payload)
    );

    assign out_valid = held_valid;
    assign stall_cnt = stall_cnt_q;

    // Bubble masking: stale data is left visible, control bits are forced 0.
    always_comb begin
        out_payload = held_payload;
        out_payload[CTRL_LO +: CTRL_W] = held_payload[CTRL_LO +: CTRL_W]
                                         & ({CTRL_W{held_valid}} | ~CTRL_MASK);
    end

    // Stall counter next value: count held-but-not-taken cycles, saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (held_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register; flush deliberately does not touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg (default widths plus a
// CNT_W=4 instance for counter saturation).
module tb_id_ex_stage_reg;

    localparam int PW = 146;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [15:0]   stall_cnt;

    logic          flush4;
    logic          in_valid4;
    logic          in_ready4;
    logic [PW-1:0] in_payload4;
    logic          out_valid4;
    logic          out_ready4;
    logic [PW-1:0] out_payload4;
    logic [3:0]    stall_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .stall_cnt   (stall_cnt)
    );

    id_ex_stage_reg #(.CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush4),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .in_payload  (in_payload4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .out_payload (out_payload4),
        .stall_cnt   (stall_cnt4)
    );

    // Build a bundle in the documented field order from a PC value.
    function automatic logic [PW-1:0] mk(input logic [31:0] pc);
        logic [4:0] ctrl;
        ctrl = {1'b1, pc[2], ~pc[2], pc[3], 1'b1};
        return {ctrl, pc[5:2], pc, pc ^ 32'hA5A5_0000, ~pc, 1'b1,
                12'h5A0 | pc[11:0], 24'hC0FFEE ^ pc[23:0], pc[5:2]};
    endfunction

    function automatic logic [31:0] get_pc(input logic [PW-1:0] p);
        return p[136:105];
    endfunction

    function automatic logic [4:0] get_ctrl(input logic [PW-1:0] p);
        return p[145:141];
    endfunction

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_payload = '0;
        flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0; in_payload4 = '0;
        #3;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_payload", out_payload, '0);
        check_eq("rst_stall", stall_cnt, 16'd0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_stall4", stall_cnt4, 4'd0);
        @(negedge clk);
        rst = 1'b1;

        // First instruction through an empty stage: 1-cycle latency.
        in_valid = 1'b1; in_payload = mk(32'h10); out_ready = 1'b1;
        tick();
        check_eq("lat_valid", out_valid, 1'b1);
        check_eq("lat_pc", get_pc(out_payload), 32'h10);
        check_eq("lat_payload", out_payload, mk(32'h10));
        check_eq("lat_in_ready", in_ready, 1'b1);

        // Back-to-back stream, one per cycle, in order.
        for (int i = 0; i < 3; i++) begin
            in_payload = mk(32'(i * 4));
            tick();
            check_eq("stream_valid", out_valid, 1'b1);
            check_eq("stream_payload", out_payload, mk(32'(i * 4)));
        end
        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", out_valid, 1'b0);
        check_eq("drain_ctrl", get_ctrl(out_payload), 5'b0);
        check_eq("drain_stall", stall_cnt, 16'd0);

        // Back-pressure: hold 0x20, offer 0x24.
        out_ready = 1'b0; in_valid = 1'b1; in_payload = mk(32'h20);
        tick();
        check_eq("bp1_pc", get_pc(out_payload), 32'h20);
        check_eq("bp1_stall", stall_cnt, 16'd0);
`ifdef ID_EX_SKID_BUFFER_EN
        check_eq("bp1_in_ready", in_ready, 1'b1);
`else
        check_eq("bp1_in_ready", in_ready, 1'b0);
`endif
        in_payload = mk(32'h24);
        tick();
        check_eq("bp2_in_ready", in_ready, 1'b0);
        check_eq("bp2_stall", stall_cnt, 16'd1);
`ifdef ID_EX_SKID_BUFFER_EN
        in_valid = 1'b0;
`endif
        tick();
        tick();
        check_eq("bp4_stall", stall_cnt, 16'd3);
        check_eq("bp4_valid", out_valid, 1'b1);
        check_eq("bp4_hold", out_payload, mk(32'h20));
        out_ready = 1'b1;
        tick();
        check_eq("bp5_payload", out_payload, mk(32'h24));
        check_eq("bp5_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        tick();
        check_eq("bp6_valid", out_valid, 1'b0);
        check_eq("bp6_stall", stall_cnt, 16'd3);

        // Flush with the stage full and an input offered.
        out_ready = 1'b0; in_valid = 1'b1; in_payload = mk(32'h30);
        tick();
        in_payload = mk(32'h34);
        tick();
        check_eq("prefl_stall", stall_cnt, 16'd4);
        flush = 1'b1; out_ready = 1'b1; in_payload = mk(32'h38);
        tick();
        check_eq("fl_valid", out_valid, 1'b0);
        check_eq("fl_wb_en", out_payload[145], 1'b0);
        check_eq("fl_mem_w", out_payload[143], 1'b0);
        check_eq("fl_in_ready", in_ready, 1'b1);
        check_eq("fl_stall", stall_cnt, 16'd4);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check_eq("postfl_valid", out_valid, 1'b0);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0; in_valid = 1'b1; in_payload = mk(32'h40);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("prerst_stall", stall_cnt, 16'd5);
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 1'b0);
        check_eq("arst_stall", stall_cnt, 16'd0);
        check_eq("arst_in_ready", in_ready, 1'b1);
        check_eq("arst_payload", out_payload, '0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1; in_valid = 1'b1; in_payload = mk(32'h50);
        tick();
        check_eq("postrst_payload", out_payload, mk(32'h50));
        check_eq("postrst_valid", out_valid, 1'b1);
        in_valid = 1'b0;

        // Saturation with a 4-bit counter.
        in_valid4 = 1'b1; in_payload4 = mk(32'h60);
        tick();
        in_valid4 = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check_eq("sat_stall14", stall_cnt4, 4'd14);
        for (int i = 0; i < 6; i++) tick();
        check_eq("sat_stall15", stall_cnt4, 4'd15);
        check_eq("sat_valid", out_valid4, 1'b1);
        check_eq("sat_payload", out_payload4, mk(32'h60));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
- REQ-001 Parameter DATA_W, default 32, width of PC, valRn, valRm fields.
- REQ-002 Parameter CMD_W, default 4, width of EXE_CMD field.
- REQ-003 Parameter DEST_W, default 4, width of destination register field.
- REQ-004 Parameter CNT_W, default 16, width of stall counter.
- REQ-005 clk  input  1  single clock; all state updates on rising edge.
- REQ-006 rst  input  1  reset, asynchronous, active-low.
- REQ-007 flush  input  1  synchronous pipeline flush (branch taken / hazard kill).
- REQ-008 in_valid  input  1  ID stage presents a valid instruction.
- REQ-009 in_ready  output  1  stage can accept an instruction this cycle.
- REQ-010 in_payload  input  PAYLOAD_W  packed ID->EXE bundle: WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, valRn, valRm, imm, shiftOperand[11:0], signedIMM[23:0], dest.
- REQ-011 out_valid  output  1  EXE stage receives a valid instruction.
- REQ-012 out_ready  input  1  EXE stage accepts this cycle.
- REQ-013 out_payload  output  PAYLOAD_W  registered bundle, same layout as in_payload.
- REQ-014 stall_cnt  output  CNT_W  count of back-pressured cycles.

Function
- REQ-015 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
- REQ-016 Latency in_payload -> out_payload is exactly 1 cycle with an empty stage; sustained throughput is 1 transfer/cycle while out_ready=1.
- REQ-017 Instructions leave in acceptance order; none duplicated or dropped except by flush.
- REQ-018 out_payload and out_valid stay constant while out_valid=1 and out_ready=0.
- REQ-019 When out_valid=0, control bits WB_EN, MEM_R_EN, MEM_W_EN, B, S of out_payload read 0 (bubble); data fields are don't-care.
- REQ-020 flush has priority: at the next edge all held entries are invalidated and any same-cycle input transfer is discarded.
- REQ-021 stall_cnt increments each cycle with out_valid=1 and out_ready=0, saturates at all-ones, and is unaffected by flush.
- REQ-022 in_valid=0 leaves state unchanged apart from output drain.

Reset
- REQ-023 While rst=0: out_valid=0, all payload/skid registers 0, stall_cnt=0, in_ready=1, immediately, independent of clk.
- REQ-024 Reset asserted mid-stall discards all held entries; first edge after release behaves as empty stage.

Configuration
- REQ-025 Macro ID_EX_SKID_BUFFER_EN defined: main plus skid register; in_ready is a flop equal to "skid empty"; input accepted while main full and out_ready=0 goes to skid, in_ready drops next cycle; on output transfer with skid full, skid moves to main and in_ready rises next cycle.
- REQ-026 Macro ID_EX_SKID_BUFFER_EN undefined: single register; in_ready = !out_valid || out_ready combinationally.

Structure
- REQ-027 Package id_ex_pkg holds default widths, field offsets, PAYLOAD_W function of parameters, and CTRL_MASK for bubble masking.
- REQ-028 Storage and handshake live in one generic sub-module pipe_skid_buf (payload-width parameter); id_ex_stage_reg adds bubble masking, flush wiring and stall_cnt.

Verification
- REQ-029 Reset then in_valid=1, PC=0x10, out_ready=1 -> next cycle out_valid=1, out_payload.PC=0x10, in_ready=1.
- REQ-030 Stream PC=0x00,0x04,0x08 with out_ready=1 -> one output per cycle, same order, no gaps.
- REQ-031 Skid build: out_ready=0 for 3 cycles, in_valid=1 PC=0x20,0x24 -> in_ready=0 after 2nd accept, stall_cnt=3, then out_ready=1 -> 0x20 then 0x24.
- REQ-032 flush=1 with main and skid full, in_valid=1 -> next cycle out_valid=0, WB_EN/MEM_W_EN out=0, in_ready=1, stall_cnt unchanged.
- REQ-033 CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt=15.
- REQ-034 rst=0 asynchronously mid-stall -> out_valid=0, stall_cnt=0 before next clk edge.
